// File: rtl/alu_ex_stage.sv
// alu_ex_stage: execute stage for the 16-bit datapath.
//   Accepts ALU requests (valid/ready) and evaluates the eight-op ALU.
//   Each result, with its flags and tag, goes into a 2-entry output FIFO
//   that drains to writeback over a second valid/ready handshake.
//   Also keeps the architectural Zero/Ofl flags of the last accepted add,
//   and a wrapping count of accepted requests.
// Optional feature: define ALU_EX_OFL_TRAP_EN to enable the overflow trap.
//   A signed add that overflows then stops intake until trap_clr is pulsed.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake
//   in_op, in_a, in_b, in_cin, in_inva, in_invb, in_sign, in_tag   request fields
//   out_valid / out_ready result handshake (FIFO head)
//   out_data, out_ofl, out_zero, out_tag                           head fields
//   flag_z, flag_v        Zero/Ofl of the last accepted add
//   op_count              accepted requests, mod 2^CNT_W
//   trap, trap_clr        overflow trap status / release (macro only)
module alu_ex_stage #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [15:0]      in_a,
   input  logic [15:0]      in_b,
   input  logic             in_cin,
   input  logic             in_inva,
   input  logic             in_invb,
   input  logic             in_sign,
   input  logic [3:0]       in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_data,
   output logic             out_ofl,
   output logic             out_zero,
   output logic [3:0]       out_tag,
   output logic             flag_z,
   output logic             flag_v,
   output logic [CNT_W-1:0] op_count,
   output logic             trap,
   input  logic             trap_clr
);

   typedef struct packed {
      logic [15:0] data;
      logic        ofl;
      logic        zero;
      logic [3:0]  tag;
   } entry_t;

   logic [15:0] opa, opb;
   logic [3:0]  sh;
   logic [31:0] rot;
   logic [16:0] sum;
   logic [15:0] res;
   logic        res_ofl, res_zero;
   logic        is_add, accept, pop, run;
   logic [1:0]  count;
   entry_t      head, tail, new_entry;

   // ALU
   always_comb begin
      opa      = in_inva ? ~in_a : in_a;
      opb      = in_invb ? ~in_b : in_b;
      sh       = opb[3:0];
      // rotate-left: shift a doubled copy so the upper half holds the result
      rot      = {opa, opa} << sh;
      sum      = {1'b0, opa} + {1'b0, opb} + {16'd0, in_cin};
      res      = '0;
      res_ofl  = 1'b0;
      case (in_op)
         3'b000: res = rot[31:16];
         3'b001: res = opa << sh;
         3'b010: res = $signed(opa) >>> sh;
         3'b011: res = opa >> sh;
         3'b100: begin
            res     = sum[15:0];
            res_ofl = in_sign ? (sum[15] ^ opa[15] ^ opb[15] ^ sum[16]) : sum[16];
         end
         3'b101: res = opa & opb;
         3'b110: res = opa | opb;
         default: res = opa ^ opb;
      endcase
      res_zero = (res == '0);
   end

   assign is_add    = (in_op == 3'b100);
   assign new_entry = '{data: res, ofl: res_ofl, zero: res_zero, tag: in_tag};

   // in_ready depends only on registered state (and reset), never on out_ready
   assign in_ready  = rst_n & run & (count != 2'd2);
   assign accept    = in_valid & in_ready;
   assign out_valid = (count != 2'd0);
   assign pop       = out_valid & out_ready;

   assign out_data  = head.data;
   assign out_ofl   = head.ofl;
   assign out_zero  = head.zero;
   assign out_tag   = head.tag;

`ifdef ALU_EX_OFL_TRAP_EN
   typedef enum logic {RUN, TRAP} state_t;
   state_t state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
      end else begin
         case (state)
            RUN:     if (accept && is_add && in_sign && res_ofl) state <= TRAP;
            TRAP:    if (trap_clr) state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

   assign run  = (state == RUN);
   assign trap = (state == TRAP);
`else
   logic unused_trap_clr;
   assign unused_trap_clr = trap_clr;
   assign run  = 1'b1;
   assign trap = 1'b0;
`endif

   // Two-slot FIFO: head drives the outputs directly, tail holds the second entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count    <= '0;
         head     <= '0;
         tail     <= '0;
         flag_z   <= 1'b0;
         flag_v   <= 1'b0;
         op_count <= '0;
      end else begin
         // accept implies count < 2, so push+pop only happens at occupancy 1
         if (pop && accept) begin
            head <= new_entry;
         end else if (pop) begin
            head  <= tail;
            count <= count - 2'd1;
         end else if (accept) begin
            if (count == 2'd0) head <= new_entry;
            else               tail <= new_entry;
            count <= count + 2'd1;
         end

         if (accept) begin
            op_count <= op_count + CNT_W'(1);
            if (is_add) begin
               flag_z <= res_zero;
               flag_v <= res_ofl;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_ex_stage.sv
`timescale 1ns/1ps
module tb_alu_ex_stage;
   localparam int unsigned CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0, in_ready;
   logic [2:0]       in_op = '0;
   logic [15:0]      in_a = '0, in_b = '0;
   logic             in_cin = 1'b0, in_inva = 1'b0, in_invb = 1'b0, in_sign = 1'b0;
   logic [3:0]       in_tag = '0;
   logic             out_valid, out_ready = 1'b0;
   logic [15:0]      out_data;
   logic             out_ofl, out_zero;
   logic [3:0]       out_tag;
   logic             flag_z, flag_v;
   logic [CNT_W-1:0] op_count;
   logic             trap, trap_clr = 1'b0;

   always #5 clk = ~clk;

   alu_ex_stage #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
      .in_inva(in_inva), .in_invb(in_invb), .in_sign(in_sign), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_ofl(out_ofl), .out_zero(out_zero), .out_tag(out_tag),
      .flag_z(flag_z), .flag_v(flag_v), .op_count(op_count),
      .trap(trap), .trap_clr(trap_clr)
   );

   int unsigned errors = 0, checks = 0;

   typedef struct {
      logic [15:0] d;
      logic        ofl;
      logic        zero;
      logic [3:0]  tag;
   } ent_t;

   // reference state
   ent_t        q[$];
   logic        m_fz = 1'b0, m_fv = 1'b0, m_trap = 1'b0;
   logic [15:0] m_cnt = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Arithmetic reference for the ALU, on plain integers.
   function automatic ent_t ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                    input logic cin, input logic inva, input logic invb, input logic sign);
      ent_t   e;
      longint x, y, sx, sy, p, r, s;
      int     sh;
      x  = inva ? 65535 - longint'(a) : longint'(a);
      y  = invb ? 65535 - longint'(b) : longint'(b);
      sh = int'(y % 16);
      p  = longint'(1) << sh;
      sx = (x >= 32768) ? x - 65536 : x;
      sy = (y >= 32768) ? y - 65536 : y;
      e.ofl = 1'b0;
      case (op)
         3'd0: r = (x * p + x / (65536 / p)) % 65536;
         3'd1: r = (x * p) % 65536;
         3'd2: begin
            r = (sx >= 0) ? sx / p : -((-sx + p - 1) / p);
            r = (r + 65536) % 65536;
         end
         3'd3: r = x / p;
         3'd4: begin
            s = x + y + longint'(cin);
            r = s % 65536;
            if (sign) e.ofl = ((sx + sy + longint'(cin)) > 32767) || ((sx + sy + longint'(cin)) < -32768);
            else      e.ofl = (s > 65535);
         end
         3'd5: r = x & y;
         3'd6: r = x | y;
         default: r = x ^ y;
      endcase
      e.d    = 16'(r);
      e.zero = (r == 0);
      e.tag  = '0;
      return e;
   endfunction

   task automatic compare_all();
      check("out_valid", out_valid, q.size() > 0);
      check("in_ready", in_ready, (q.size() < 2) && !m_trap);
      check("op_count", op_count, m_cnt);
      check("flag_z", flag_z, m_fz);
      check("flag_v", flag_v, m_fv);
      check("trap", trap, m_trap);
      if (q.size() > 0) begin
         check("out_data", out_data, q[0].d);
         check("out_tag", out_tag, q[0].tag);
         check("out_ofl", out_ofl, q[0].ofl);
         check("out_zero", out_zero, q[0].zero);
      end
   endtask

   // Called just after a falling edge: check, drive, advance one cycle, update model.
   task automatic step(input logic v, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic inva, input logic invb, input logic sign,
                       input logic [3:0] tag, input logic ordy, input logic clr);
      ent_t e;
      logic acc, pp, was_trap;
      compare_all();
      in_valid = v; in_op = op; in_a = a; in_b = b; in_cin = cin;
      in_inva = inva; in_invb = invb; in_sign = sign; in_tag = tag;
      out_ready = ordy; trap_clr = clr;
      acc = v && (q.size() < 2) && !m_trap;
      pp  = (q.size() > 0) && ordy;
      was_trap = m_trap;
      e = ref_alu(op, a, b, cin, inva, invb, sign);
      e.tag = tag;
      @(posedge clk);
      if (pp) void'(q.pop_front());
      if (acc) begin
         q.push_back(e);
         m_cnt++;
         if (op == 3'd4) begin
            m_fz = e.zero;
            m_fv = e.ofl;
         end
`ifdef ALU_EX_OFL_TRAP_EN
         if (op == 3'd4 && sign && e.ofl) m_trap = 1'b1;
`endif
      end
      if (was_trap && clr) m_trap = 1'b0;
      @(negedge clk);
   endtask

   task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic inva, input logic sign,
                        input logic [3:0] tag, input logic ordy);
      step(1'b1, op, a, b, cin, inva, 1'b0, sign, tag, ordy, 1'b0);
   endtask

   task automatic idle(input logic ordy, input logic clr);
      step(1'b0, 3'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, ordy, clr);
   endtask

   // Called just after a falling edge; asserts reset between edges.
   task automatic do_reset();
      in_valid = 1'b0; out_ready = 1'b0; trap_clr = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_data", out_data, 16'h0000);
      check("rst_out_tag", out_tag, 4'h0);
      check("rst_out_ofl", out_ofl, 1'b0);
      check("rst_out_zero", out_zero, 1'b0);
      check("rst_flag_z", flag_z, 1'b0);
      check("rst_flag_v", flag_v, 1'b0);
      check("rst_op_count", op_count, 16'd0);
      check("rst_trap", trap, 1'b0);
      q.delete();
      m_cnt = '0; m_fz = 1'b0; m_fv = 1'b0; m_trap = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("rst_release_ready", in_ready, 1'b1);
      @(negedge clk);
   endtask

   logic [2:0]  d_op[4]   = '{3'd0, 3'd2, 3'd3, 3'd5};
   logic [15:0] d_a[4]    = '{16'h8001, 16'h8000, 16'h8000, 16'h00FF};
   logic [15:0] d_b[4]    = '{16'h0004, 16'h0003, 16'h0003, 16'h0F0F};
   logic        d_inva[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
   logic [15:0] d_exp[4]  = '{16'h0018, 16'hF000, 16'h1000, 16'h0F00};

   initial begin
      @(negedge clk);
      do_reset();

      // signed overflow
      issue(3'd4, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0);
      check("sovf_data", out_data, 16'h8000);
      check("sovf_ofl", out_ofl, 1'b1);
      check("sovf_zero", out_zero, 1'b0);
      check("sovf_flag_v", flag_v, 1'b1);
`ifdef ALU_EX_OFL_TRAP_EN
      check("sovf_trap", trap, 1'b1);
      check("sovf_in_ready", in_ready, 1'b0);
      idle(1'b1, 1'b0);
      check("trap_hold", trap, 1'b1);
      check("trap_drained", out_valid, 1'b0);
      idle(1'b0, 1'b1);
      check("trap_cleared", trap, 1'b0);
      check("trap_clr_ready", in_ready, 1'b1);
`else
      check("sovf_no_trap", trap, 1'b0);
      idle(1'b1, 1'b0);
`endif

      // unsigned wrap
      issue(3'd4, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0);
      check("uwrap_data", out_data, 16'h0000);
      check("uwrap_ofl", out_ofl, 1'b1);
      check("uwrap_zero", out_zero, 1'b1);
      check("uwrap_flag_z", flag_z, 1'b1);
      check("uwrap_trap", trap, 1'b0);
      idle(1'b1, 1'b0);

      // shifts and inversion
      for (int i = 0; i < 4; i++) begin
         issue(d_op[i], d_a[i], d_b[i], 1'b0, d_inva[i], 1'b0, 4'(i + 3), 1'b0);
         check("dir_result", out_data, d_exp[i]);
         idle(1'b1, 1'b0);
      end

      // backpressure
      do_reset();
      issue(3'd7, 16'h1234, 16'h00FF, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
      issue(3'd6, 16'h0F00, 16'h000F, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);
      check("bp_full_ready", in_ready, 1'b0);
      issue(3'd5, 16'hAAAA, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0);
      check("bp_head_tag1", out_tag, 4'd1);
      issue(3'd5, 16'hAAAA, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1);
      check("bp_head_tag2", out_tag, 4'd2);
      check("bp_count2", op_count, 16'd2);
      issue(3'd5, 16'hAAAA, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1);
      check("bp_head_tag3", out_tag, 4'd3);
      check("bp_count3", op_count, 16'd3);
      idle(1'b1, 1'b0);
      check("bp_empty", out_valid, 1'b0);

      // push+pop at occupancy 1, then at occupancy 2
      issue(3'd6, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0);
      issue(3'd6, 16'h0006, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd6, 1'b1);
      check("pp_occ1_tag", out_tag, 4'd6);
      check("pp_occ1_ready", in_ready, 1'b1);
      issue(3'd6, 16'h0007, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0);
      issue(3'd6, 16'h0008, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd8, 1'b1);
      check("pp_occ2_tag", out_tag, 4'd7);
      check("pp_occ2_count", op_count, 16'd6);
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b0);

      // randomized traffic
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         step(($urandom % 4) != 0, 3'($urandom), 16'($urandom), 16'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              4'($urandom), ($urandom % 3) != 0, ($urandom % 4) == 0);
      end
      idle(1'b1, 1'b1);
      idle(1'b1, 1'b0);

      // reset mid-stream with a full FIFO
      do_reset();
      for (int i = 0; i < 4; i++) issue(3'd5, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0, 4'(i), 1'b1);
      issue(3'd5, 16'h00FF, 16'h00F0, 1'b0, 1'b0, 1'b0, 4'd9, 1'b0);
      compare_all();
      check("mid_count5", op_count, 16'd5);
      check("mid_full", in_ready, 1'b0);
      do_reset();
      compare_all();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_ex_stage.md
# alu_ex_stage

Execute-stage wrapper for the 16-bit datapath. It accepts ALU requests from decode over a valid/ready handshake and evaluates them with the team's eight-op ALU function (rotate/shift/add/logic with operand inversion, carry-in and sign). Results, with their flags, go into a 2-entry output FIFO that drains to writeback over a second valid/ready handshake. It also keeps an architectural flag register, an operation counter and an optional overflow-trap state machine.

## Interface
- CNT_W, 16, width of the accepted-operation counter (wraps).

- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  stage can accept.
- in_op  in  3  ALU opcode.
- in_a, in_b  in  16  operands, pre-inversion.
- in_cin  in  1  carry-in for add.
- in_inva, in_invb  in  1  invert A / B before use.
- in_sign  in  1  signed overflow mode for add.
- in_tag  in  4  opaque id, returned with result.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_data  out  16  result.
- out_ofl, out_zero  out  1  result flags.
- out_tag  out  4  tag of head.
- flag_z, flag_v  out  1  Zero/Ofl of last accepted add.
- op_count  out  CNT_W  accepted requests, mod 2^CNT_W.
- trap  out  1  overflow trap active (macro only; else 0).
- trap_clr  in  1  leave trap state (macro only; else ignored).

## Operation
- Operand prep: A = in_inva ? ~in_a : in_a; B = in_invb ? ~in_b : in_b; sh = B[3:0].
- 000: rotate A left by sh. 001: A << sh, zero fill. 010: A >> sh, arithmetic (A[15] fill). 011: A >> sh, logical.
- 100: 17-bit sum S = A + B + in_cin; result S[15:0].
  - Ofl: if in_sign = 1, Ofl = carry into bit 15 XOR carry out (S[15]^A[15]^B[15]^S[16]); otherwise Ofl = S[16].
- 101: A & B. 110: A | B. 111: A ^ B.
- Flags for every op: out_zero = (result == 0). out_ofl = 0 for all ops except 100.
- Accept = in_valid & in_ready.
  - On accept, the result, flags and in_tag are written to the FIFO tail.
  - op_count increments on accept.
  - On an add accept, flag_z/flag_v load that add's Zero/Ofl. Other ops leave flag_z/flag_v unchanged.
- FIFO:
  - 2 entries, occupancy 0..2; strict order.
  - Pop = out_valid & out_ready.
  - in_ready = (occupancy < 2) & (state == RUN). No combinational path from out_ready to in_ready.
  - Push and pop in the same cycle leave occupancy unchanged.
  - At occupancy 2 no push occurs, even if a pop happens that cycle.
- out_* presents the FIFO head. Head data holds stable while out_valid & ~out_ready.
- States: RUN (and TRAP only when the macro is defined).

## Timing
- Latency: a request accepted at edge N is visible on out_valid/out_data after edge N (one cycle) if the FIFO was empty.
- Throughput: 1 request/cycle while the consumer keeps out_ready = 1.
- Reset (rst_n low, asynchronous) forces the following:
  - occupancy 0, out_valid 0, out_data/out_tag/out_ofl/out_zero 0.
  - flag_z 0, flag_v 0, op_count 0, state RUN, trap 0.
  - in_ready 0 while rst_n is low, and 1 on the first cycle after release.
- Reset mid-operation discards FIFO contents; no partial pop is visible.

## Configuration
- ALU_EX_OFL_TRAP_EN defined:
  - An accepted add with in_sign = 1 and Ofl = 1 moves the state to TRAP at that edge. The overflowing result is still pushed.
  - In TRAP: trap = 1 and in_ready = 0. The FIFO continues to drain.
  - trap_clr = 1 in TRAP returns the state to RUN at the next edge. trap_clr is ignored in RUN.
  - If trap_clr coincides with reset, reset wins.
- ALU_EX_OFL_TRAP_EN undefined:
  - No TRAP state; trap tied 0; trap_clr unused.
  - Unsigned overflow never traps in either configuration.

## Test plan
- Signed overflow: add, a=0x7FFF, b=0x0001, cin=0, sign=1 -> out_data 0x8000, out_ofl 1, out_zero 0, flag_v 1.
  - With the macro: trap 1 and in_ready 0 until a trap_clr pulse; in_ready 1 one cycle later.
- Unsigned wrap: add, a=0xFFFF, b=0x0001, sign=0 -> out_data 0x0000, out_ofl 1, out_zero 1, flag_z 1, trap stays 0.
- Shifts and inversion:
  - rotl a=0x8001, b=0x0004 -> 0x0018.
  - sra a=0x8000, b=0x0003 -> 0xF000.
  - srl a=0x8000, b=0x0003 -> 0x1000.
  - and a=0x00FF, b=0x0F0F, inva=1 -> 0x0F00.
- Backpressure: out_ready=0; offer tags 1, 2, 3 back-to-back -> in_ready falls after tag 2 is accepted.
  - Raise out_ready -> tags come out 1, 2, then 3 is accepted; op_count = 3.
- Simultaneous push/pop at occupancy 1 -> occupancy stays 1, order preserved.
  - At occupancy 2 with out_ready=1 -> no push that cycle.
- Reset mid-stream: FIFO full, op_count=5, rst_n pulsed low between edges -> out_valid 0 immediately, op_count 0, flags 0, in_ready 1 after release.
